// File: rtl/sfp_accum.sv
// sfp_accum
// -----------------------------------------------------------------------------
// Purpose:
//    Accumulates a stream of small floating-point (SFP) terms into a
//    two's-complement fixed-point sum. Each term is decoded to an integer
//    magnitude, signed by (term sign XOR Hadamard coefficient), and added to
//    a running accumulator. The beat flagged as last closes the sum. The
//    closed sum is then held on the output until the downstream stage takes it.
//
// Configuration:
//    SFP_ACCUM_SAT_EN - when defined, a sum that overflows clamps to
//                       +/-(2^(fixWidth-1)-1). Accumulation then continues
//                       from the clamped value. When the macro is undefined,
//                       the sum wraps modulo 2^fixWidth. out_ovf is
//                       produced in both builds.
//
// Ports:
//    clk        - single clock, rising-edge active
//    rst        - synchronous active-high reset
//    in_valid   - in_sfp / in_neg / in_last carry a beat
//    in_ready   - block can accept a beat this cycle
//    in_sfp     - SFP term {sign, exp, mant}
//    in_neg     - 1 subtracts the term, 0 adds it
//    in_last    - beat is the final term of the current sum
//    out_valid  - out_fix holds a completed sum
//    out_ready  - downstream consumes out_fix this cycle
//    out_fix    - completed two's-complement sum
//    out_ovf    - overflow occurred at some point during the held sum
// -----------------------------------------------------------------------------
module sfp_accum #(
    parameter int expWidth    = 4,
    parameter int sigWidth    = 4,
    parameter int formatWidth = 9,
    parameter int fixWidth    = 21
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [formatWidth-1:0] in_sfp,
    input  logic                   in_neg,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [fixWidth-1:0]    out_fix,
    output logic                   out_ovf
);

    // Two guard bits give headroom, so one add of a term to an in-range
    // accumulator can never wrap before the range check sees it.
    localparam int accWidth = fixWidth + 2;

    // The legal range is symmetric, so the most negative code counts as overflow.
    localparam logic signed [accWidth-1:0] maxVal = {3'b000, {(fixWidth-1){1'b1}}};
    localparam logic signed [accWidth-1:0] minVal = -maxVal;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                r_state;
    logic [fixWidth-1:0]   r_acc;
    logic                  r_sumOvf;
    logic                  r_outValid;
    logic [fixWidth-1:0]   r_outFix;
    logic                  r_outOvf;

    logic                  w_sign;
    logic [expWidth-1:0]   w_exp;
    logic [sigWidth-1:0]   w_mant;
    logic [accWidth-1:0]   w_mag;
    logic                  w_effNeg;
    logic signed [accWidth-1:0] w_accExt;
    logic signed [accWidth-1:0] w_sum;
    logic                  w_beatOvf;
    logic [fixWidth-1:0]   w_newAcc;
    logic                  w_newOvf;
    logic                  w_accept;

    // Split the SFP word into its fields.
    assign w_sign = in_sfp[formatWidth-1];
    assign w_exp  = in_sfp[sigWidth+expWidth-1 -: expWidth];
    assign w_mant = in_sfp[sigWidth-1:0];

    // Upstream may send whenever the output slot is empty or is drained this cycle.
    assign in_ready = !r_outValid || out_ready;
    assign w_accept = in_valid && in_ready;

    // Magnitude decode: exp==0 is an exact zero. Otherwise the hidden one is
    // restored and the significand is shifted up by (exp-1). This makes
    // exp=1 an unscaled {1,mant}.
    always_comb begin
        w_mag = '0;
        if (w_exp != '0) begin
            w_mag = {{(accWidth-sigWidth-1){1'b0}}, 1'b1, w_mant} << (w_exp - 1'b1);
        end
    end

    // Signed add/subtract at the widened width, followed by the range check.
    // The wrapped accumulator is sign-extended, so a wrapped partial sum is
    // treated as its two's-complement value from then on.
    assign w_effNeg  = w_sign ^ in_neg;
    assign w_accExt  = {{2{r_acc[fixWidth-1]}}, r_acc};
    assign w_sum     = w_effNeg ? (w_accExt - w_mag) : (w_accExt + w_mag);
    assign w_beatOvf = (w_sum > maxVal) || (w_sum < minVal);
    assign w_newOvf  = r_sumOvf | w_beatOvf;

    // The next accumulator value either clamps to the symmetric limit or
    // keeps the low fixWidth bits.
`ifdef SFP_ACCUM_SAT_EN
    always_comb begin
        w_newAcc = w_sum[fixWidth-1:0];
        if (w_sum > maxVal) begin
            w_newAcc = maxVal[fixWidth-1:0];
        end else if (w_sum < minVal) begin
            w_newAcc = minVal[fixWidth-1:0];
        end
    end
`else
    assign w_newAcc = w_sum[fixWidth-1:0];
`endif

    // Control FSM and datapath registers.
    // ACC collects beats. HOLD presents a finished sum. A beat accepted in
    // HOLD can only arrive while the held sum is drained. That beat starts
    // the next sum straight away, so the stream has no bubble. If that beat
    // is also last, the next result replaces the old one and the FSM stays
    // in HOLD. The accumulator and the sticky flag are cleared whenever a
    // sum closes, so the next accepted beat always starts from zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ACC;
            r_acc      <= '0;
            r_sumOvf   <= 1'b0;
            r_outValid <= 1'b0;
            r_outFix   <= '0;
            r_outOvf   <= 1'b0;
        end else begin
            case (r_state)
                ACC: begin
                    if (w_accept && in_last) begin
                        r_outFix   <= w_newAcc;
                        r_outOvf   <= w_newOvf;
                        r_outValid <= 1'b1;
                        r_acc      <= '0;
                        r_sumOvf   <= 1'b0;
                        r_state    <= HOLD;
                    end else if (w_accept) begin
                        r_acc    <= w_newAcc;
                        r_sumOvf <= w_newOvf;
                    end
                end
                HOLD: begin
                    if (w_accept && in_last) begin
                        r_outFix   <= w_newAcc;
                        r_outOvf   <= w_newOvf;
                        r_outValid <= 1'b1;
                        r_acc      <= '0;
                        r_sumOvf   <= 1'b0;
                    end else if (out_ready) begin
                        r_outValid <= 1'b0;
                        r_state    <= ACC;
                        if (w_accept) begin
                            r_acc    <= w_newAcc;
                            r_sumOvf <= w_newOvf;
                        end
                    end
                end
                default: begin
                    r_state <= ACC;
                end
            endcase
        end
    end

    assign out_valid = r_outValid;
    assign out_fix   = r_outFix;
    assign out_ovf   = r_outOvf;

endmodule

// File: tb/tb_sfp_accum.sv
// tb_sfp_accum
// -----------------------------------------------------------------------------
// Purpose:
//    Directed testbench for sfp_accum. The bench applies hand-computed
//    vectors. It checks the results with immediate assertions. Expected
//    values for overflowing sums depend on whether SFP_ACCUM_SAT_EN is
//    defined.
// -----------------------------------------------------------------------------
module tb_sfp_accum;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  in_sfp;
    logic        in_neg;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [20:0] out_fix;
    logic        out_ovf;

    int checks;
    int errors;

    sfp_accum #(
        .expWidth   (4),
        .sigWidth   (4),
        .formatWidth(9),
        .fixWidth   (21)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_sfp   (in_sfp),
        .in_neg   (in_neg),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_fix  (out_fix),
        .out_ovf  (out_ovf)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Safety net so the run always ends, even if the stimulus stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired got running want finished");
        $fatal(1, "[TB] watchdog");
    end

    // Drive one set of input values.
    task automatic applyStimulus(input logic valid, input logic [8:0] sfp,
                                 input logic neg, input logic last,
                                 input logic oReady);
        in_valid  = valid;
        in_sfp    = sfp;
        in_neg    = neg;
        in_last   = last;
        out_ready = oReady;
    endtask

    // Advance one clock edge and settle so outputs are sampled away from it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check out_valid. When a result is expected, also check out_fix and out_ovf.
    task automatic checkOutput(input string tag, input logic expValid,
                               input logic [20:0] expFix, input logic expOvf);
        checks++;
        assert (out_valid === expValid) else begin
            errors++;
            $error("[TB] FAIL %s out_valid got %0b want %0b", tag, out_valid, expValid);
        end
        if (expValid) begin
            checks++;
            assert (out_fix === expFix) else begin
                errors++;
                $error("[TB] FAIL %s out_fix got %h want %h", tag, out_fix, expFix);
            end
            checks++;
            assert (out_ovf === expOvf) else begin
                errors++;
                $error("[TB] FAIL %s out_ovf got %0b want %0b", tag, out_ovf, expOvf);
            end
        end
    endtask

    // Check the combinational in_ready.
    task automatic checkReady(input string tag, input logic expReady);
        checks++;
        assert (in_ready === expReady) else begin
            errors++;
            $error("[TB] FAIL %s in_ready got %0b want %0b", tag, in_ready, expReady);
        end
    endtask

    // Directed sequence.
    initial begin
        logic [20:0] ovfExp;
`ifdef SFP_ACCUM_SAT_EN
        ovfExp = 21'h0FFFFF;
`else
        ovfExp = 21'h174000;
`endif
        checks = 0;
        errors = 0;
        rst = 1'b1;
        applyStimulus(1'b0, 9'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();

        // Reset state.
        checks++;
        assert (out_fix === 21'd0 && out_ovf === 1'b0) else begin
            errors++;
            $error("[TB] FAIL reset_out got fix=%h ovf=%0b want fix=0 ovf=0", out_fix, out_ovf);
        end
        checkOutput("reset_valid", 1'b0, 21'd0, 1'b0);
        rst = 1'b0;
        #1;
        checkReady("reset_ready", 1'b1);

        // 32 + 16 = 48.
        applyStimulus(1'b1, 9'b0_0010_0000, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("sum48_mid", 1'b0, 21'd0, 1'b0);
        applyStimulus(1'b1, 9'b0_0001_0000, 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("sum48", 1'b1, 21'd48, 1'b0);
        applyStimulus(1'b0, 9'd0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("sum48_drain", 1'b0, 21'd0, 1'b0);

        // An idle cycle does not disturb the zeroed accumulator.
        tick();

        // Single beat subtracted gives -32.
        applyStimulus(1'b1, 9'b0_0010_0000, 1'b1, 1'b1, 1'b1);
        tick();
        checkOutput("neg32", 1'b1, 21'h1FFFE0, 1'b0);

        // Negative sign XOR in_neg=1 adds. Accepted during HOLD with out_ready=1.
        applyStimulus(1'b1, 9'b1_0010_0000, 1'b1, 1'b1, 1'b1);
        tick();
        checkOutput("signxor_pos32", 1'b1, 21'd32, 1'b0);
        applyStimulus(1'b0, 9'd0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("signxor_drain", 1'b0, 21'd0, 1'b0);

        // Largest single term: exp=15 mant=15 -> 507904.
        applyStimulus(1'b1, 9'b0_1111_1111, 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("maxterm", 1'b1, 21'd507904, 1'b0);
        applyStimulus(1'b0, 9'd0, 1'b0, 1'b0, 1'b1);
        tick();

        // Three max terms overflow on the third beat.
        applyStimulus(1'b1, 9'b0_1111_1111, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        applyStimulus(1'b1, 9'b0_1111_1111, 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("overflow3", 1'b1, ovfExp, 1'b1);

        // Sticky flag clears for the next sum (started in the drain cycle).
        applyStimulus(1'b1, 9'b0_0001_0000, 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("ovf_cleared", 1'b1, 21'd16, 1'b0);
        applyStimulus(1'b0, 9'd0, 1'b0, 1'b0, 1'b1);
        tick();

        // Backpressure: hold +32 for five cycles while a beat waits.
        applyStimulus(1'b1, 9'b0_0010_0000, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("bp_load", 1'b1, 21'd32, 1'b0);
        applyStimulus(1'b1, 9'b0_0001_0000, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            checkReady("bp_ready_low", 1'b0);
            checkOutput("bp_hold", 1'b1, 21'd32, 1'b0);
            tick();
        end
        applyStimulus(1'b1, 9'b0_0001_0000, 1'b0, 1'b1, 1'b1);
        #1;
        checkReady("bp_ready_high", 1'b1);
        tick();
        checkOutput("bp_nobubble16", 1'b1, 21'd16, 1'b0);

        // A non-last beat accepted in the drain cycle starts the next sum: 32 + 16.
        applyStimulus(1'b1, 9'b0_0010_0000, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("handoff_mid", 1'b0, 21'd0, 1'b0);
        applyStimulus(1'b1, 9'b0_0001_0000, 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("handoff48", 1'b1, 21'd48, 1'b0);
        applyStimulus(1'b0, 9'd0, 1'b0, 1'b0, 1'b1);
        tick();

        // Reset after 2 of 4 beats discards the partial sum.
        applyStimulus(1'b1, 9'b0_0010_0000, 1'b0, 1'b0, 1'b1);
        tick();
        tick();
        rst = 1'b1;
        applyStimulus(1'b0, 9'd0, 1'b0, 1'b0, 1'b1);
        tick();
        rst = 1'b0;
        checkOutput("midreset_valid", 1'b0, 21'd0, 1'b0);
        applyStimulus(1'b1, 9'b0_0010_0000, 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("midreset32", 1'b1, 21'd32, 1'b0);
        applyStimulus(1'b0, 9'd0, 1'b0, 1'b0, 1'b1);
        tick();

        // exp=0 terms are zero but still count as beats: lone zero, then 32 + 0 + 16.
        applyStimulus(1'b1, 9'b0_0000_1111, 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("zero_last", 1'b1, 21'd0, 1'b0);
        applyStimulus(1'b1, 9'b0_0010_0000, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 9'b1_0000_1111, 1'b0, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 9'b0_0001_0000, 1'b0, 1'b1, 1'b1);
        tick();
        checkOutput("zero_mid48", 1'b1, 21'd48, 1'b0);
        applyStimulus(1'b0, 9'd0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("final_drain", 1'b0, 21'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
